// File: rtl/beam_pkg.sv
// Shared types and helpers for the delay-and-sum beamformer.
// Saturating output is selected with BEAM_DELAY_SUM_SAT_EN.
package beam_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // Accumulator width with enough headroom to add n_ch full-scale samples.
    function automatic int unsigned acc_w(input int unsigned in_w, input int unsigned n_ch);
        return in_w + $clog2(n_ch);
    endfunction

    // Returns {below_min, above_max} for a value against a signed out_w-bit range.
    function automatic logic [1:0] sat_dir(input logic signed [63:0] v,
                                           input int unsigned out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        return {(v < lo), (v > hi)};
    endfunction

endpackage

// File: rtl/beam_sample_ring.sv
// Per-channel sample ring: DEPTH x IN_W register file, synchronous write, asynchronous read.
module beam_sample_ring
    import beam_pkg::*;
#(
    parameter int unsigned IN_W  = 19,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [IN_W-1:0] i_wr_data,
    input  logic [AW-1:0]   i_rd_addr,
    output logic [IN_W-1:0] o_rd_data
);

    logic [IN_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/beam_delay_sum.sv
// Delay-and-sum beamformer core: per-channel ring delay, serial accumulate, scaled output.
// Define BEAM_DELAY_SUM_SAT_EN to clamp the output instead of wrapping.
module beam_delay_sum
    import beam_pkg::*;
#(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned IN_W      = 19,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned OUT_SHIFT = 4,
    localparam int unsigned CW       = $clog2(N_CH),
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [N_CH*IN_W-1:0]   i_in_data,
    input  logic                   i_cfg_we,
    input  logic [CW-1:0]          i_cfg_ch,
    input  logic [AW-1:0]          i_cfg_delay,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic signed [OUT_W-1:0] o_out_data,
    output logic                   o_overrun
);

    localparam int unsigned ACC_W = acc_w(IN_W, N_CH);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_delay  [N_CH];
    logic [AW-1:0]           r_shadow [N_CH];
    logic signed [ACC_W-1:0] r_acc;
    logic [CW-1:0]           r_ch_cnt;
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_overrun;

    logic                    w_accept;
    logic                    w_load_out;
    logic                    w_handshake;
    logic [IN_W-1:0]         w_rd_data [N_CH];
    logic [IN_W-1:0]         w_sel;
    logic signed [ACC_W-1:0] w_sel_ext;
    logic signed [OUT_W-1:0] w_out_next;

    // All rings read in parallel at their own delayed slot; the counter picks one per cycle.
    for (genvar c = 0; c < N_CH; c++) begin : g_ring
        logic [AW-1:0] w_rd_addr;

        assign w_rd_addr = r_wr_ptr - r_shadow[c];

        beam_sample_ring #(
            .IN_W  (IN_W),
            .DEPTH (DEPTH)
        ) u_ring (
            .clk       (clk),
            .rst       (rst),
            .i_we      (w_accept),
            .i_wr_addr (r_wr_ptr),
            .i_wr_data (i_in_data[c*IN_W +: IN_W]),
            .i_rd_addr (w_rd_addr),
            .o_rd_data (w_rd_data[c])
        );
    end

    assign w_sel     = w_rd_data[r_ch_cnt];
    assign w_sel_ext = {{(ACC_W - IN_W){w_sel[IN_W-1]}}, w_sel};

`ifdef BEAM_DELAY_SUM_SAT_EN
    logic signed [ACC_W-1:0] w_shifted;
    logic [1:0]              w_sat;

    assign w_shifted = r_acc >>> OUT_SHIFT;
    assign w_sat     = sat_dir({{(64 - ACC_W){w_shifted[ACC_W-1]}}, w_shifted}, OUT_W);

    always_comb begin
        w_out_next = w_shifted[OUT_W-1:0];
        if (w_sat[0]) begin
            w_out_next = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (w_sat[1]) begin
            w_out_next = {1'b1, {(OUT_W - 1){1'b0}}};
        end
    end
`else
    assign w_out_next = OUT_W'(r_acc >>> OUT_SHIFT);
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load_out   = 1'b0;
        w_handshake  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (r_ch_cnt == CW'(N_CH - 1)) begin
                    w_state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (!r_out_valid) begin
                    w_load_out = 1'b1;
                end else if (i_out_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_acc       <= '0;
            r_ch_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_delay[i]  <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_overrun <= i_in_valid && (r_state != IDLE);

            if (i_cfg_we && (32'(i_cfg_ch) < N_CH)) begin
                r_delay[i_cfg_ch] <= i_cfg_delay;
            end

            // Shadow copy freezes the delays for the whole frame being summed.
            if (w_accept) begin
                for (int i = 0; i < N_CH; i++) begin
                    r_shadow[i] <= r_delay[i];
                end
                r_acc    <= '0;
                r_ch_cnt <= '0;
            end

            if (r_state == ACCUM) begin
                r_acc    <= r_acc + w_sel_ext;
                r_ch_cnt <= r_ch_cnt + 1'b1;
            end

            if (w_load_out) begin
                r_out_data  <= w_out_next;
                r_out_valid <= 1'b1;
            end

            if (w_handshake) begin
                r_out_valid <= 1'b0;
                r_wr_ptr    <= r_wr_ptr + 1'b1;
            end
        end
    end

    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_overrun   = r_overrun;

endmodule
